// File: rtl/result_store_writer.sv
// result_store_writer
//   Moves one tile of result beats from the compute array into BRAM port A.
//   A store is started with start_store. It takes TILE_SMALL or TILE_LARGE
//   beats, depending on Tiles_Control. Each accepted beat is written one
//   cycle after its handshake. The word offset keeps running from one store
//   to the next until reset_addr_counter clears it while the block is idle.
//
// Ports
//   clk, rst_n            : single clock, asynchronous active-low reset
//   start_store           : one-cycle store request, honoured only in IDLE
//   reset_addr_counter    : clears the running word offset, honoured only in IDLE
//   Buffer_Select[2:0]    : target buffer region, forms the top bits of addra
//   Tiles_Control         : 1 = TILE_SMALL words, 0 = TILE_LARGE words
//   in_valid/in_data      : result beat from the compute array
//   in_ready              : writer accepts a beat this cycle
//   ena/wea/addra/dina    : BRAM port-A write interface (registered)
//   store_done            : pulses together with the final write of a store
//   busy                  : a store is in progress
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start_store; offset may be cleared here
// WRITE  | accepting beats; in_ready=1, remain_q counts beats still owed
// DONE   | final write on port A, store_done=1; lasts one cycle
module result_store_writer #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 256,
   parameter int TILE_SMALL = 32,
   parameter int TILE_LARGE = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_store,
   input  logic                  reset_addr_counter,
   input  logic [2:0]            Buffer_Select,
   input  logic                  Tiles_Control,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  ena,
   output logic                  wea,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dina,
   output logic                  store_done,
   output logic                  busy
);

   localparam int OFF_W = ADDR_WIDTH - 3;
   localparam int CNT_W = $clog2(((TILE_LARGE > TILE_SMALL) ? TILE_LARGE : TILE_SMALL) + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q;
   logic [OFF_W-1:0] offset_q;
   logic [CNT_W-1:0] remain_q;
   logic [2:0]       bsel_q;
   logic             beat;
   logic             last_beat;

   // The tile size is only needed to load the beat counter, so the latched
   // Tiles_Control lives on as remain_q and needs no register of its own.
   assign beat      = (state_q == S_WRITE) && in_valid;
   assign last_beat = beat && (remain_q == CNT_W'(1));

   assign in_ready = (state_q == S_WRITE);
   assign busy     = (state_q != S_IDLE);
   assign ena      = busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         offset_q   <= '0;
         remain_q   <= '0;
         bsel_q     <= '0;
         wea        <= 1'b0;
         store_done <= 1'b0;
         addra      <= '0;
         dina       <= '0;
      end else begin
         wea        <= beat;
         store_done <= last_beat;

         if (beat) begin
            addra    <= {bsel_q, offset_q};
            dina     <= in_data;
            offset_q <= offset_q + OFF_W'(1);
            remain_q <= remain_q - CNT_W'(1);
         end

         case (state_q)
            S_IDLE: begin
               // A clear and a start in the same cycle both take effect,
               // so the new store begins at offset 0.
               if (reset_addr_counter) begin
                  offset_q <= '0;
               end
               if (start_store) begin
                  bsel_q   <= Buffer_Select;
                  remain_q <= Tiles_Control ? CNT_W'(TILE_SMALL) : CNT_W'(TILE_LARGE);
                  state_q  <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (last_beat) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_store_writer.sv
module tb_result_store_writer;

   localparam int AW = 16;
   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_store;
   logic          reset_addr_counter;
   logic [2:0]    Buffer_Select;
   logic          Tiles_Control;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          ena;
   logic          wea;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic          store_done;
   logic          busy;

   always #5 clk = ~clk;

   result_store_writer #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TILE_SMALL(32),
      .TILE_LARGE(512)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start_store        (start_store),
      .reset_addr_counter (reset_addr_counter),
      .Buffer_Select      (Buffer_Select),
      .Tiles_Control      (Tiles_Control),
      .in_valid           (in_valid),
      .in_data            (in_data),
      .in_ready           (in_ready),
      .ena                (ena),
      .wea                (wea),
      .addra              (addra),
      .dina               (dina),
      .store_done         (store_done),
      .busy               (busy)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   logic [12:0] m_off;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int base, input int k);
      return {32'(32'hC0DE_0000 + k), 192'h0, 32'(base + k)};
   endfunction

   task automatic push_exp(input logic [2:0] bsel, input logic [DW-1:0] d, input logic last);
      exp_t e;
      e.addr = {bsel, m_off};
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
      m_off++;
   endtask

   task automatic reset_checks();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ena", ena, 0);
      chk("rst_wea", wea, 0);
      chk("rst_store_done", store_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addra", addra, 0);
      chk("rst_dina", dina, 0);
   endtask

   // Scoreboard monitor: every write on port A must match the oldest
   // expected write. store_done may only appear with the final write.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wea) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual addra=%0h required=no write", addra);
            end else begin
               mon_e = exp_q.pop_front();
               chk("addra", addra, mon_e.addr);
               chk("dina", dina, mon_e.data);
               chk("store_done", store_done, mon_e.last);
               chk("ena_on_write", ena, 1);
            end
         end else begin
            chk("store_done_no_write", store_done, 0);
         end
      end
   end

   // abuse: 0 none, 1 start/Buffer_Select/Tiles_Control changed mid-store,
   //        2 reset_addr_counter pulsed mid-store
   task automatic do_store(input logic [2:0] bsel, input logic tc, input bit gaps,
                           input int abuse, input bit clr, input int base, input bit rel_rst);
      int n;
      int k;
      int cyc;
      bit v;
      n   = tc ? 32 : 512;
      k   = 0;
      cyc = 0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      if (rel_rst) rst_n = 1'b1;
      start_store        = 1'b1;
      Buffer_Select      = bsel;
      Tiles_Control      = tc;
      reset_addr_counter = clr;
      if (clr) m_off = '0;
      while (k < n && cyc < 4 * n + 8) begin
         @(negedge clk);
         start_store        = 1'b0;
         reset_addr_counter = 1'b0;
         chk("write_in_ready", in_ready, 1);
         chk("write_busy", busy, 1);
         if (abuse == 1 && cyc == 5) begin
            start_store   = 1'b1;
            Buffer_Select = ~bsel;
            Tiles_Control = ~tc;
         end
         if (abuse == 2 && cyc == 3) reset_addr_counter = 1'b1;
         v        = gaps ? (cyc % 2 == 0) : 1'b1;
         in_valid = v;
         in_data  = mk(base, k);
         @(posedge clk);
         if (v) begin
            push_exp(bsel, mk(base, k), k == n - 1);
            k++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid           = 1'b0;
      start_store        = 1'b0;
      reset_addr_counter = 1'b0;
      checks++;
      if (k < n) begin
         failures++;
         $display("FAIL store_timeout actual=%0d beats required=%0d beats", k, n);
      end
      chk("done_busy", busy, 1);
      chk("done_in_ready", in_ready, 0);
      @(negedge clk);
      chk("end_busy", busy, 0);
      chk("end_ena", ena, 0);
      chk("end_in_ready", in_ready, 0);
   endtask

   initial begin
      rst_n              = 1'b0;
      start_store        = 1'b0;
      reset_addr_counter = 1'b0;
      Buffer_Select      = 3'b000;
      Tiles_Control      = 1'b0;
      in_valid           = 1'b0;
      in_data            = '0;
      m_off              = '0;

      repeat (2) @(negedge clk);
      #1 reset_checks();
      @(negedge clk);
      rst_n = 1'b1;

      // Small tile from offset 0: 0x6000..0x601F, data = k
      do_store(3'b011, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

      // Large tile with valid gaps; clear and start together -> 0x2000..0x21FF
      do_store(3'b001, 1'b0, 1'b1, 0, 1'b1, 1000, 1'b0);

      // Standalone clear in IDLE, two small stores continue 0..31, 32..63,
      // the second with a clear pulse during WRITE that must be ignored
      @(negedge clk);
      reset_addr_counter = 1'b1;
      m_off              = '0;
      @(negedge clk);
      reset_addr_counter = 1'b0;
      do_store(3'b100, 1'b1, 1'b0, 0, 1'b0, 2000, 1'b0);
      do_store(3'b100, 1'b1, 1'b0, 2, 1'b0, 3000, 1'b0);
      @(negedge clk);
      reset_addr_counter = 1'b1;
      m_off              = '0;
      @(negedge clk);
      reset_addr_counter = 1'b0;
      do_store(3'b100, 1'b1, 1'b0, 0, 1'b0, 4000, 1'b0);

      // Mid-store start/Buffer_Select/Tiles_Control changes are ignored
      do_store(3'b101, 1'b1, 1'b0, 1, 1'b0, 5000, 1'b0);

      // Reset after 10 beats of a large store: immediate abort, no store_done
      @(negedge clk);
      start_store   = 1'b1;
      Buffer_Select = 3'b110;
      Tiles_Control = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start_store = 1'b0;
         in_valid    = 1'b1;
         in_data     = mk(8000, k);
         @(posedge clk);
         push_exp(3'b110, mk(8000, k), 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 reset_checks();
      chk("abort_pending_writes", DW'(exp_q.size()), 0);
      m_off = '0;
      repeat (3) @(negedge clk);
      chk("abort_busy_held", busy, 0);
      chk("abort_store_done_held", store_done, 0);
      // Start presented on the very first edge after reset release
      do_store(3'b010, 1'b1, 1'b0, 0, 1'b0, 6000, 1'b1);

      // Offsets move in whole tiles, so wrap is crossed by a large store
      // starting at 8160: 0x1FE0..0x1FFF then 0x0000..0x01DF
      for (int i = 0; i < 15; i++) do_store(3'b111, 1'b0, 1'b0, 0, (i == 0), 10000 + i * 1000, 1'b0);
      for (int i = 0; i < 15; i++) do_store(3'b110, 1'b1, 1'b0, 0, 1'b0, 30000 + i * 100, 1'b0);
      do_store(3'b000, 1'b0, 1'b0, 0, 1'b0, 50000, 1'b0);

      @(negedge clk);
      chk("writes_outstanding", DW'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_store_writer.md
RESULT_STORE_WRITER -- requirements
Module: result_store_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, BRAM port-A word address width.
REQ-002 Parameter DATA_WIDTH, default 256, BRAM port-A data width and input beat width.
REQ-003 Parameter TILE_SMALL, default 32, words per store when Tiles_Control=1.
REQ-004 Parameter TILE_LARGE, default 512, words per store when Tiles_Control=0.
REQ-005 Port clk, input, 1, single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port start_store, input, 1, one-cycle request to begin one store transfer.
REQ-008 Port reset_addr_counter, input, 1, clears the running word offset.
REQ-009 Port Buffer_Select, input, 3, target buffer region.
REQ-010 Port Tiles_Control, input, 1, tile size select: 1 = TILE_SMALL, 0 = TILE_LARGE.
REQ-011 Port in_valid, input, 1, result beat valid from the compute array.
REQ-012 Port in_data, input, DATA_WIDTH, result beat payload.
REQ-013 Port in_ready, output, 1, writer accepts a beat this cycle.
REQ-014 Port ena, output, 1, BRAM port-A enable.
REQ-015 Port wea, output, 1, BRAM port-A write enable.
REQ-016 Port addra, output, ADDR_WIDTH, BRAM port-A address.
REQ-017 Port dina, output, DATA_WIDTH, BRAM port-A write data.
REQ-018 Port store_done, output, 1, one-cycle pulse when the last word of a transfer is written.
REQ-019 Port busy, output, 1, transfer in progress.

Function
REQ-020 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-021 In IDLE, when start_store=1, the block SHALL latch Buffer_Select and Tiles_Control, load word count N (32 or 512), and enter WRITE on the next edge.
REQ-022 In WRITE, in_ready SHALL be 1; in IDLE and DONE, in_ready SHALL be 0.
REQ-023 A beat SHALL transfer only on a cycle with in_valid=1 and in_ready=1; with in_valid=0 the block SHALL stall with no write and no count change.
REQ-024 The write for a beat SHALL appear one cycle after its handshake, with all outputs registered:
- wea=1 and ena=1
- addra = {latched Buffer_Select, offset[ADDR_WIDTH-4:0]}
- dina = the captured in_data
REQ-025 On cycles with no write, wea SHALL be 0; ena SHALL stay 1 while busy.
REQ-026 The running offset SHALL increment by 1 per accepted beat, wrap modulo 2^(ADDR_WIDTH-3) (8191 -> 0), and persist across transfers.
REQ-027 After the N-th beat is accepted, the FSM SHALL enter DONE, and store_done SHALL be 1 in the same cycle the final wea=1 is presented.
REQ-028 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-029 busy SHALL be 1 in WRITE and DONE, and 0 in IDLE.
REQ-030 start_store SHALL be ignored while busy=1.
REQ-031 Buffer_Select and Tiles_Control changes while busy=1 SHALL have no effect on the current transfer.
REQ-032 reset_addr_counter SHALL take effect only in IDLE and SHALL be ignored in WRITE and DONE.
REQ-033 If reset_addr_counter and start_store are both 1 in IDLE, the offset SHALL be cleared first and the transfer SHALL start at offset 0.

Reset
REQ-034 While rst_n=0, outputs SHALL be:
- state = IDLE, offset = 0
- in_ready=0, ena=0, wea=0, store_done=0, busy=0
- addra=0, dina=0
REQ-035 Reset asserted mid-transfer SHALL abort the transfer immediately, with no store_done pulse.
REQ-036 After reset deassertion, the block SHALL accept a new start_store on the first rising edge.

Verification
REQ-037 Small tile: Buffer_Select=3'b011, Tiles_Control=1, offset 0, 32 back-to-back beats with in_data=k -> addra 0x6000..0x601F, dina=k, store_done on the cycle with addra=0x601F, then busy=0.
REQ-038 Large tile with gaps: Buffer_Select=3'b001, Tiles_Control=0, in_valid toggled every other cycle -> exactly 512 writes at 0x2000..0x21FF with no write on stall cycles.
REQ-039 Offset continuation and reset: two consecutive small stores -> second covers offsets 32..63; then reset_addr_counter in IDLE -> third starts at offset 0; reset_addr_counter pulsed during WRITE -> ignored.
REQ-040 Wrap: reach offset 8190, then a small store on Buffer_Select=3'b000 -> addra 0x1FFE, 0x1FFF, 0x0000..0x001D.
REQ-041 Protocol abuse: start_store, Buffer_Select and Tiles_Control changed mid-transfer -> ignored; rst_n=0 after 10 beats -> all outputs 0 at once, no store_done, and a restart works.
